// File: rtl/ysyx_25040109_lsu_pkg.sv
// Shared definitions for the multi-cycle load/store unit.
//   - funct3 encodings for loads and stores
//   - exception cause encoding reported on out_cause
//   - FSM state encoding
//   - decode helpers for funct3 legality and natural alignment
package ysyx_25040109_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        CAUSE_LOAD_MISALIGN  = 2'd0,
        CAUSE_LOAD_FAULT     = 2'd1,
        CAUSE_STORE_MISALIGN = 2'd2,
        CAUSE_STORE_FAULT    = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // Double-word forms exist only on a 64-bit datapath.
    function automatic logic funct3_legal(input logic is_load, input logic [2:0] f3,
                                          input logic is_rv64);
        logic ok;
        ok = 1'b0;
        if (is_load) begin
            case (f3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
                F3_LD, F3_LWU:                       ok = is_rv64;
                default:                             ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_SB, F3_SH, F3_SW: ok = 1'b1;
                F3_SD:               ok = is_rv64;
                default:             ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Access size is funct3[1:0] for both classes; require natural alignment.
    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] low_addr);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = low_addr[0];
            2'b10:   mis = |low_addr[1:0];
            2'b11:   mis = |low_addr;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_25040109_lsu_align.sv
// Combinational byte-lane alignment for the LSU.
//   funct3     in   access type (size in [1:0], unsigned flag in [2])
//   offset     in   byte offset of the access inside the bus word
//   store_data in   rs2 value, right-aligned
//   load_word  in   full bus word returned by memory
//   bus_wdata  out  store data moved to its byte lane
//   bus_wstrb  out  byte-enable mask for the store
//   load_data  out  selected load bytes, sign- or zero-extended
module ysyx_25040109_lsu_align
    import ysyx_25040109_lsu_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int OFF_W  = $clog2(XLEN / 8),
    localparam int STRB_W = XLEN / 8
) (
    input  logic [2:0]        funct3,
    input  logic [OFF_W-1:0]  offset,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   load_word,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [STRB_W-1:0] bus_wstrb,
    output logic [XLEN-1:0]   load_data
);

    logic [OFF_W+2:0] shamt;
    logic [XLEN-1:0]  sized_data;
    logic [XLEN-1:0]  lane;

    // NOTE: every always_comb output gets a value on every path (case defaults
    // included) so no latch can be inferred.
    always_comb begin
        shamt = {offset, 3'b000};

        // Clear bytes above the access size so unused lanes carry zeros.
        case (funct3[1:0])
            2'b00:   sized_data = XLEN'(store_data[7:0]);
            2'b01:   sized_data = XLEN'(store_data[15:0]);
            2'b10:   sized_data = XLEN'(store_data[31:0]);
            default: sized_data = store_data;
        endcase
        bus_wdata = sized_data << shamt;

        case (funct3[1:0])
            2'b00:   bus_wstrb = STRB_W'(1'b1)  << offset;
            2'b01:   bus_wstrb = STRB_W'(2'b11) << offset;
            2'b10:   bus_wstrb = STRB_W'(4'hF)  << offset;
            default: bus_wstrb = '1;
        endcase

        // Bring the addressed bytes down to bit 0, then extend from there.
        lane = load_word >> shamt;
        case (funct3)
            F3_LB:   load_data = XLEN'($signed(lane[7:0]));
            F3_LBU:  load_data = XLEN'(lane[7:0]);
            F3_LH:   load_data = XLEN'($signed(lane[15:0]));
            F3_LHU:  load_data = XLEN'(lane[15:0]);
            F3_LW:   load_data = XLEN'($signed(lane[31:0]));
            F3_LWU:  load_data = XLEN'(lane[31:0]);
            default: load_data = lane;
        endcase
    end

endmodule

// File: rtl/ysyx_25040109_lsu_mc.sv
// Multi-cycle load/store unit between EXU and WBU.
//   clock, reset                synchronous active-high reset
//   in_*                        operation from EXU (valid/ready)
//   mem_req_*                   memory request (valid/ready), lane-aligned
//   mem_resp_*                  memory response strobe, always accepted
//   out_*                       result to WBU (valid/ready) with exception info
// Every output is either a flop or a decode of the state register.
module ysyx_25040109_lsu_mc
    import ysyx_25040109_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic [2:0]          in_funct3,
    input  logic                in_is_load,
    input  logic                in_is_store,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wstrb,
    input  logic                mem_resp_valid,
    input  logic [XLEN-1:0]     mem_resp_rdata,
    input  logic                mem_resp_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_rdata,
    output logic                out_exc,
    output logic [1:0]          out_cause
);

    localparam int   OFF_W   = $clog2(XLEN / 8);
    localparam int   STRB_W  = XLEN / 8;
    localparam logic IS_RV64 = (XLEN == 64);

    state_e              state_q, state_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                is_load_q, is_load_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                req_wen_q, req_wen_d;
    logic [XLEN-1:0]     req_wdata_q, req_wdata_d;
    logic [STRB_W-1:0]   req_wstrb_q, req_wstrb_d;
    logic [XLEN-1:0]     out_rdata_q, out_rdata_d;
    logic                out_exc_q, out_exc_d;
    cause_e              out_cause_q, out_cause_d;

    logic [2:0]          align_funct3;
    logic [OFF_W-1:0]    align_off;
    logic [XLEN-1:0]     align_wdata;
    logic [STRB_W-1:0]   align_wstrb;
    logic [XLEN-1:0]     align_load;

    // One aligner serves both directions: in IDLE it sees the incoming store,
    // afterwards the latched access type for extracting the response.
    assign align_funct3 = (state_q == ST_IDLE) ? in_funct3 : funct3_q;
    assign align_off    = (state_q == ST_IDLE) ? in_addr[OFF_W-1:0] : off_q;

    ysyx_25040109_lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (align_funct3),
        .offset     (align_off),
        .store_data (in_wdata),
        .load_word  (mem_resp_rdata),
        .bus_wdata  (align_wdata),
        .bus_wstrb  (align_wstrb),
        .load_data  (align_load)
    );

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        is_load_d   = is_load_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        out_rdata_d = out_rdata_q;
        out_exc_d   = out_exc_q;
        out_cause_d = out_cause_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    off_d     = in_addr[OFF_W-1:0];
                    funct3_d  = in_funct3;
                    is_load_d = in_is_load;
                    if (!in_is_load && !in_is_store) begin
                        state_d     = ST_WB;
                        out_rdata_d = '0;
                        out_exc_d   = 1'b0;
                        out_cause_d = CAUSE_LOAD_MISALIGN;
                    end else if (!funct3_legal(in_is_load, in_funct3, IS_RV64) ||
                                 misaligned(in_funct3, in_addr[2:0])) begin
                        // Rejected before any bus activity: no partial access.
                        state_d     = ST_WB;
                        out_rdata_d = '0;
                        out_exc_d   = 1'b1;
                        if (in_is_load) out_cause_d = CAUSE_LOAD_MISALIGN;
                        else            out_cause_d = CAUSE_STORE_MISALIGN;
                    end else begin
                        state_d     = ST_REQ;
                        req_addr_d  = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        req_wen_d   = in_is_store;
                        req_wdata_d = in_is_store ? align_wdata : '0;
                        req_wstrb_d = in_is_store ? align_wstrb : '0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (mem_resp_valid) begin
                    state_d = ST_WB;
                    if (mem_resp_err) begin
                        out_rdata_d = '0;
                        out_exc_d   = 1'b1;
                        if (is_load_q) out_cause_d = CAUSE_LOAD_FAULT;
                        else           out_cause_d = CAUSE_STORE_FAULT;
                    end else begin
                        out_rdata_d = is_load_q ? align_load : '0;
                        out_exc_d   = 1'b0;
                        out_cause_d = CAUSE_LOAD_MISALIGN;
                    end
                end
            end
            ST_WB: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge value of the others, independent of statement order.
    // Datapath flops are reset too, since their reset values are visible on
    // the ports.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            off_q       <= '0;
            funct3_q    <= '0;
            is_load_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            out_rdata_q <= '0;
            out_exc_q   <= 1'b0;
            out_cause_q <= CAUSE_LOAD_MISALIGN;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            is_load_q   <= is_load_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            out_rdata_q <= out_rdata_d;
            out_exc_q   <= out_exc_d;
            out_cause_q <= out_cause_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign mem_req_valid = (state_q == ST_REQ);
    assign out_valid     = (state_q == ST_WB);
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wen   = req_wen_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wstrb = req_wstrb_q;
    assign out_rdata     = out_rdata_q;
    assign out_exc       = out_exc_q;
    assign out_cause     = out_cause_q;

endmodule
